// File: rtl/conv_stream_pkg.sv
// ============================================================================
// Module : conv_stream_pkg
// Brief  : Shared types, sizing helpers and default derived constants for the
//          conv feature-map streaming blocks.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_stream_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  // Index width that never collapses to zero bits for single-entry dimensions.
  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    while ((64'(1) << r) < 64'(value)) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int out_dim(input int in_dim, input int filt);
    return in_dim - filt + 1;
  endfunction

  localparam int DEF_H = 32;
  localparam int DEF_W = 32;
  localparam int DEF_F = 3;
  localparam int DEF_K = 2;
  localparam int OH    = out_dim(DEF_H, DEF_F);
  localparam int OW    = out_dim(DEF_W, DEF_F);
  localparam int N     = DEF_K * OH * OW;

endpackage

`default_nettype wire

// File: rtl/fmap_index_counter.sv
// ============================================================================
// Module : fmap_index_counter
// Brief  : Nested channel/row/column counter (column fastest) with clear,
//          enable and a last-position flag.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fmap_index_counter
  import conv_stream_pkg::*;
#(
  parameter int CH_N  = 2,
  parameter int ROW_N = 2,
  parameter int COL_N = 2,
  parameter int CH_W  = clog2_min1(CH_N),
  parameter int ROW_W = clog2_min1(ROW_N),
  parameter int COL_W = clog2_min1(COL_N)
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CH_W-1:0]  ch_o,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o,
  output logic             last_o
);

  localparam logic [CH_W-1:0]  C_CH_MAX  = CH_W'(CH_N - 1);
  localparam logic [ROW_W-1:0] C_ROW_MAX = ROW_W'(ROW_N - 1);
  localparam logic [COL_W-1:0] C_COL_MAX = COL_W'(COL_N - 1);

  logic [CH_W-1:0]  ch_q,  ch_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      ch_q  <= '0;
      row_q <= '0;
      col_q <= '0;
    end else begin
      ch_q  <= ch_d;
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  // Clear wins over enable so a restart always begins at the origin.
  always_comb begin
    ch_d  = ch_q;
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      ch_d  = '0;
      row_d = '0;
      col_d = '0;
    end else if (en_i) begin
      if (col_q == C_COL_MAX) begin
        col_d = '0;
        if (row_q == C_ROW_MAX) begin
          row_d = '0;
          ch_d  = (ch_q == C_CH_MAX) ? '0 : ch_q + 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  assign ch_o   = ch_q;
  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = (ch_q == C_CH_MAX) && (row_q == C_ROW_MAX) && (col_q == C_COL_MAX);

endmodule

`default_nettype wire

// File: rtl/conv_fmap_streamer.sv
// ============================================================================
// Module : conv_fmap_streamer
// Brief  : Captures a flat K-channel feature map on load and streams it out one
//          word per valid/ready transfer with ch/row/col tags and a last flag.
//          Optional macro OUT_RELU_EN zeroes words whose sign bit is set.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_fmap_streamer
  import conv_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int H          = 32,
  parameter int W          = 32,
  parameter int F          = 3,
  parameter int K          = 2
) (
  input  logic                                                       clk,
  input  logic                                                       reset,
  input  logic                                                       load,
  input  logic [K*out_dim(H,F)*out_dim(W,F)*DATA_WIDTH-1:0]          fmap_in,
  output logic                                                       busy,
  output logic [DATA_WIDTH-1:0]                                      out_data,
  output logic                                                       out_valid,
  input  logic                                                       out_ready,
  output logic [clog2_min1(K)-1:0]                                   out_ch,
  output logic [clog2_min1(out_dim(H,F))-1:0]                        out_row,
  output logic [clog2_min1(out_dim(W,F))-1:0]                        out_col,
  output logic                                                       out_last
);

  localparam int C_OH = out_dim(H, F);
  localparam int C_OW = out_dim(W, F);
  localparam int C_N  = K * C_OH * C_OW;
  localparam int C_BW = C_N * DATA_WIDTH;

  state_e            state_q, state_d;
  logic [C_BW-1:0]   buf_q, buf_d;
  logic              cnt_clr;
  logic              cnt_en;
  logic              cnt_last;
  logic [DATA_WIDTH-1:0] raw_word;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
    end
  end

  // After the final shift the buffer is all zero, so out_data idles at 0.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          buf_d   = fmap_in;
          cnt_clr = 1'b1;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (out_ready) begin
          buf_d  = buf_q >> DATA_WIDTH;
          cnt_en = 1'b1;
          if (cnt_last) begin
            cnt_clr = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  fmap_index_counter #(
    .CH_N  (K),
    .ROW_N (C_OH),
    .COL_N (C_OW)
  ) u_idx (
    .clk_i    (clk),
    .reset_ni (reset),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .ch_o     (out_ch),
    .row_o    (out_row),
    .col_o    (out_col),
    .last_o   (cnt_last)
  );

  assign raw_word  = buf_q[DATA_WIDTH-1:0];
  assign busy      = (state_q == ST_STREAM);
  assign out_valid = (state_q == ST_STREAM);
  assign out_last  = out_valid && cnt_last;

`ifdef OUT_RELU_EN
  assign out_data = raw_word[DATA_WIDTH-1] ? '0 : raw_word;
`else
  assign out_data = raw_word;
`endif

endmodule

`default_nettype wire

// File: tb/tb_conv_fmap_streamer.sv
// ============================================================================
// Module : tb_conv_fmap_streamer
// Brief  : Scoreboard bench for conv_fmap_streamer (H=W=4, F=3, K=2, N=8).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_fmap_streamer;

  localparam int DW  = 32;
  localparam int H   = 4;
  localparam int W   = 4;
  localparam int F   = 3;
  localparam int K   = 2;
  localparam int OH  = H - F + 1;
  localparam int OW  = W - F + 1;
  localparam int N   = K * OH * OW;
  localparam int FW  = N * DW;

  typedef struct {
    logic [DW-1:0] data;
    int            ch;
    int            row;
    int            col;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load = 1'b0;
  logic [FW-1:0] fmap_in = '0;
  logic          busy;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [0:0]    out_ch;
  logic [0:0]    out_row;
  logic [0:0]    out_col;
  logic          out_last;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  conv_fmap_streamer #(
    .DATA_WIDTH (DW),
    .H          (H),
    .W          (W),
    .F          (F),
    .K          (K)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .fmap_in   (fmap_in),
    .busy      (busy),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected stream for a captured map, element n in ascending order.
  task automatic push_stream(input logic [FW-1:0] v);
    exp_t e;
    for (int n = 0; n < N; n++) begin
      e.data = v[n*DW +: DW];
`ifdef OUT_RELU_EN
      if (e.data[DW-1]) e.data = '0;
`endif
      e.ch   = n / (OH * OW);
      e.row  = (n % (OH * OW)) / OW;
      e.col  = n % OW;
      e.last = (n == N - 1);
      exp_q.push_back(e);
    end
  endtask

  function automatic logic [FW-1:0] ramp(input int base);
    logic [FW-1:0] v;
    v = '0;
    for (int n = 0; n < N; n++) v[n*DW +: DW] = DW'(base + n);
    return v;
  endfunction

  task automatic wait_idle(input int budget);
    int cnt;
    cnt = 0;
    while (busy && cnt < budget) begin
      tick();
      cnt++;
    end
    chk("idle_timeout", longint'(busy), 0);
    chk("sb_empty", longint'(exp_q.size()), 0);
  endtask

  task automatic start(input logic [FW-1:0] v);
    fmap_in = v;
    load    = 1'b1;
    push_stream(v);
    tick();
    load    = 1'b0;
  endtask

  // Monitor: whenever an element is presented it must equal the queue head;
  // the head is retired only on a transfer, so stalls must hold the values.
  always @(negedge clk) begin
    if (reset && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_element", longint'(out_data), 0);
      end else begin
        chk("data", longint'(out_data), longint'(exp_q[0].data));
        chk("ch",   longint'(out_ch),   longint'(exp_q[0].ch));
        chk("row",  longint'(out_row),  longint'(exp_q[0].row));
        chk("col",  longint'(out_col),  longint'(exp_q[0].col));
        chk("last", longint'(out_last), longint'(exp_q[0].last));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [FW-1:0] v;
    int i;
    bit pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    // Reset state
    tick(); tick();
    chk("rst_busy",  longint'(busy), 0);
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_last",  longint'(out_last), 0);
    chk("rst_data",  longint'(out_data), 0);
    chk("rst_idx",   longint'({out_ch, out_row, out_col}), 0);
    reset = 1'b1;
    tick();

    // 1: full-rate stream, words 1..8
    out_ready = 1'b1;
    start(ramp(1));
    chk("t1_busy_first", longint'(busy), 1);
    chk("t1_data_first", longint'(out_data), 1);
    repeat (7) tick();
    chk("t1_last_at_8", longint'(out_last), 1);
    chk("t1_data_8", longint'(out_data), 8);
    tick();
    chk("t1_busy_after", longint'(busy), 0);
    chk("t1_valid_after", longint'(out_valid), 0);
    chk("t1_idx_after", longint'({out_ch, out_row, out_col}), 0);
    chk("t1_sb_empty", longint'(exp_q.size()), 0);
    tick();

    // 2: ready pattern 1,0,0,1,...
    start(ramp(1));
    i = 0;
    while (busy && i < 40) begin
      out_ready = pat[i % 4];
      tick();
      i++;
    end
    out_ready = 1'b1;
    wait_idle(4);
    tick();

    // 3: second load mid-stream is ignored
    start(ramp(1));
    tick(); tick();
    fmap_in = ramp(100);
    load    = 1'b1;
    tick();
    load    = 1'b0;
    wait_idle(20);
    tick();

    // 4: reset after the third transfer, then restart from word 0
    start(ramp(1));
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    chk("t4_valid", longint'(out_valid), 0);
    chk("t4_busy",  longint'(busy), 0);
    chk("t4_idx",   longint'({out_ch, out_row, out_col}), 0);
    chk("t4_data",  longint'(out_data), 0);
    exp_q.delete();
    reset = 1'b1;
    tick();
    start(ramp(1));
    chk("t4_restart_data", longint'(out_data), 1);
    wait_idle(20);
    tick();

    // 5: load on the final-transfer cycle is ignored; a load one cycle later works
    start(ramp(1));
    repeat (7) tick();
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("t5_busy_after_final", longint'(busy), 0);
    chk("t5_valid_after_final", longint'(out_valid), 0);
    chk("t5_sb_empty", longint'(exp_q.size()), 0);
    start(ramp(11));
    chk("t5_busy_fresh", longint'(busy), 1);
    chk("t5_data_fresh", longint'(out_data), 11);
    wait_idle(20);
    tick();

    // 6: sign-bit words (ReLU zeroes 0xBF800000 only when enabled)
    v = ramp(1);
    v[2*DW +: DW] = 32'hBF800000;
    v[3*DW +: DW] = 32'h3F800000;
    start(v);
    tick(); tick();
`ifdef OUT_RELU_EN
    chk("t6_word2", longint'(out_data), 0);
`else
    chk("t6_word2", longint'(out_data), longint'(32'hBF800000));
`endif
    tick();
    chk("t6_word3", longint'(out_data), longint'(32'h3F800000));
    wait_idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/conv_fmap_streamer.md
Name: conv_fmap_streamer

Overview:
Reader side of the flattened convolution-output bus. Captures one complete K-channel feature map, presented as a single wide flat word by the multi-filter conv layer, on a load strobe. Streams it out one DATA_WIDTH word per transfer over a valid/ready interface, tagged with channel/row/column indices and a last flag. Sits between the conv stage and downstream serial consumers (pooling, memory writer, debug UART).

Parameters:
DATA_WIDTH, 32, bits per feature-map element
H, 32, input image height seen by the conv stage
W, 32, input image width seen by the conv stage
F, 3, filter size; output height OH = H-F+1, output width OW = W-F+1
K, 2, number of channels (filters) in the feature map

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
load  input  1  capture request; accepted only when busy=0
fmap_in  input  K*OH*OW*DATA_WIDTH  flat feature map; word n at bits [n*DATA_WIDTH +: DATA_WIDTH]
busy  output  1  high from the cycle after an accepted load until the final transfer completes
out_data  output  DATA_WIDTH  current element
out_valid  output  1  out_data and indices are valid
out_ready  input  1  downstream accepts the element
out_ch  output  max(1,clog2(K))  channel index k
out_row  output  max(1,clog2(OH))  row index r
out_col  output  max(1,clog2(OW))  column index c
out_last  output  1  high with the final element (n = N-1)

Behaviour:
- N = K*OH*OW. Element order is n = k*OH*OW + r*OW + c, ascending n. Column varies fastest, then row, then channel.
- Reset (reset=0 at a clock edge): state=IDLE; busy, out_valid, out_last = 0; out_data, out_ch, out_row, out_col = 0; buffer cleared. Reset mid-stream aborts the stream immediately; no further elements are emitted.
- FSM has two states, IDLE and STREAM.
- IDLE: when load=1, fmap_in is registered into an N-word shift buffer, indices are set to 0, and state becomes STREAM. Next cycle: busy=1, out_valid=1, out_data = word 0.
- STREAM: a transfer occurs on a cycle with out_valid && out_ready.
  - On a transfer, the buffer shifts right by DATA_WIDTH.
  - col increments; at OW-1 it wraps to 0 and row increments.
  - Row at OH-1 wraps to 0 and ch increments.
- With out_valid=1 and out_ready=0: out_data, indices and out_last hold stable. out_valid never drops before its transfer.
- out_last = 1 exactly when ch=K-1, row=OH-1, col=OW-1.
- Final transfer: state returns to IDLE. The next cycle has out_valid=0, busy=0 and indices=0.
- load while busy=1, including the final-transfer cycle, is ignored. No queueing.
- Throughput is one element per cycle with out_ready tied high. A full map takes N cycles, plus 1 load cycle.
- Latency from load to first out_valid is 1 cycle.
- Degenerate N=1: the first element carries out_last=1.

Optional Feature:
OUT_RELU_EN
- Defined: each emitted element has ReLU applied. If out_data's MSB (sign, IEEE-754 or two's complement) is 1, out_data is driven to 0; otherwise the word passes unchanged. Applied combinationally on the buffer output, so latency is unchanged.
- Undefined: raw words are emitted.

Decomposition:
- Package conv_stream_pkg holds:
  - the clog2 helper function
  - derived constants OH, OW and N
  - state encoding ST_IDLE=1'b0, ST_STREAM=1'b1
- One natural sub-module, fmap_index_counter. It is a nested ch/row/col counter with enable, clear and a last output, reusable by a future streaming loader for the image bus.

Test Plan:
- Params H=4, W=4, F=3, K=2 (N=8); fmap_in word n = n+1; out_ready=1; single load. Required: 8 elements with data 1..8 on consecutive cycles. (ch,row,col) runs (0,0,0),(0,0,1),(0,1,0),(0,1,1),(1,0,0)..(1,1,1). out_last only on data=8; busy falls the cycle after.
- Same setup with out_ready toggled 1,0,0,1,... Required: data/indices hold during stalls, no element is dropped or duplicated, and the order is still 1..8.
- Load pulsed again mid-stream with different fmap_in. Required: the second load is ignored and the original data 1..8 completes.
- reset=0 asserted after the 3rd transfer. Required: next cycle out_valid=0, busy=0, indices=0; a new load restarts from word 0.
- Load asserted in the same cycle as the final transfer. Required: ignored, busy=0 afterwards; a load one cycle later starts a fresh stream.
- OUT_RELU_EN defined; word 2 = 32'hBF800000 (-1.0), word 3 = 32'h3F800000. Required: outputs 0 and 32'h3F800000. Without the macro, 32'hBF800000 passes unchanged.
